// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle for id_ex_stage: decoded operands and control,
// stall/flush controls, forwarding sources and the ALU-facing outputs.
interface id_ex_stage_if;
    logic        id_valid;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic [4:0]  id_rd_addr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic        id_use_imm;
    logic [3:0]  id_alu_ctrl;
    logic [4:0]  id_shmt;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        hold;
    logic        flush;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic [31:0] BusA;
    logic [31:0] BusB;
    logic [31:0] shift;
    logic [3:0]  ALUCtrl;
    logic [4:0]  shmt;
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [4:0]  ex_rd;
    logic [31:0] ex_store_data;
    logic        load_use_stall;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
               id_imm, id_use_imm, id_alu_ctrl, id_shmt, id_reg_write, id_mem_read,
               id_mem_write, hold, flush, exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  BusA, BusB, shift, ALUCtrl, shmt, ex_valid, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_rd, ex_store_data, load_use_stall
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
               id_imm, id_use_imm, id_alu_ctrl, id_shmt, id_reg_write, id_mem_read,
               id_mem_write, hold, flush, exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output BusA, BusB, shift, ALUCtrl, shmt, ex_valid, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_rd, ex_store_data, load_use_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and MEM/WB,
// load-use hazard detection and bubble insertion.
module id_ex_stage (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);

    logic        r_valid;
    logic [4:0]  r_rs_addr;
    logic [4:0]  r_rt_addr;
    logic [4:0]  r_rd_addr;
    logic [31:0] r_rs_data;
    logic [31:0] r_rt_data;
    logic [31:0] r_imm;
    logic        r_use_imm;
    logic [3:0]  r_alu_ctrl;
    logic [4:0]  r_shmt;
    logic        r_reg_write;
    logic        r_mem_read;
    logic        r_mem_write;

    logic        stall;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;
    logic [31:0] bus_b;

    // Load in EX whose destination is a source of the decoding instruction.
    always_comb begin
        stall = r_valid && r_mem_read && (r_rd_addr != 5'd0) && bus.id_valid &&
                ((r_rd_addr == bus.id_rs_addr) ||
                 ((r_rd_addr == bus.id_rt_addr) && !bus.id_use_imm));
    end

    // Pipeline register: hold beats bubble beats capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_rs_addr   <= '0;
            r_rt_addr   <= '0;
            r_rd_addr   <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_use_imm   <= 1'b0;
            r_alu_ctrl  <= '0;
            r_shmt      <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (bus.hold) begin
            r_valid <= r_valid;
        end else if (bus.flush || stall) begin
            r_valid     <= 1'b0;
            r_rs_addr   <= '0;
            r_rt_addr   <= '0;
            r_rd_addr   <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_use_imm   <= 1'b0;
            r_alu_ctrl  <= '0;
            r_shmt      <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_valid     <= bus.id_valid;
            r_rs_addr   <= bus.id_rs_addr;
            r_rt_addr   <= bus.id_rt_addr;
            r_rd_addr   <= bus.id_rd_addr;
            r_rs_data   <= bus.id_rs_data;
            r_rt_data   <= bus.id_rt_data;
            r_imm       <= bus.id_imm;
            r_use_imm   <= bus.id_use_imm;
            r_alu_ctrl  <= bus.id_alu_ctrl;
            r_shmt      <= bus.id_shmt;
            r_reg_write <= bus.id_reg_write && bus.id_valid;
            r_mem_read  <= bus.id_mem_read  && bus.id_valid;
            r_mem_write <= bus.id_mem_write && bus.id_valid;
        end
    end

    // Operand forwarding; the younger EX/MEM result wins, r0 never forwards.
    always_comb begin
        fwd_rs = r_rs_data;
        if (bus.exmem_reg_write && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == r_rs_addr))
            fwd_rs = bus.exmem_result;
        else if (bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == r_rs_addr))
            fwd_rs = bus.memwb_result;

        fwd_rt = r_rt_data;
        if (bus.exmem_reg_write && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == r_rt_addr))
            fwd_rt = bus.exmem_result;
        else if (bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == r_rt_addr))
            fwd_rt = bus.memwb_result;

        bus_b = r_use_imm ? r_imm : fwd_rt;
    end

    // ALU-facing outputs.
    always_comb begin
        bus.BusA           = fwd_rs;
        bus.BusB           = bus_b;
        bus.shift          = bus_b >> r_shmt;
        bus.ALUCtrl        = r_alu_ctrl;
        bus.shmt           = r_shmt;
        bus.ex_valid       = r_valid;
        bus.ex_reg_write   = r_reg_write;
        bus.ex_mem_read    = r_mem_read;
        bus.ex_mem_write   = r_mem_write;
        bus.ex_rd          = r_rd_addr;
        bus.ex_store_data  = fwd_rt;
        bus.load_use_stall = stall;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, forwarding priority, r0
// suppression, load-use bubble, immediate/shift paths, hold/flush and reset.
module tb_id_ex_stage;

    logic clk;
    logic rst_n;
    int unsigned vectors;
    int unsigned miscompares;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare observed against expected and report any miscompare.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_valid = 1'b0;     bus.id_rs_addr = '0;    bus.id_rt_addr = '0;
        bus.id_rd_addr = '0;     bus.id_rs_data = '0;    bus.id_rt_data = '0;
        bus.id_imm = '0;         bus.id_use_imm = 1'b0;  bus.id_alu_ctrl = '0;
        bus.id_shmt = '0;        bus.id_reg_write = 1'b0; bus.id_mem_read = 1'b0;
        bus.id_mem_write = 1'b0; bus.hold = 1'b0;        bus.flush = 1'b0;
        bus.exmem_reg_write = 1'b0; bus.exmem_rd = '0;   bus.exmem_result = '0;
        bus.memwb_reg_write = 1'b0; bus.memwb_rd = '0;   bus.memwb_result = '0;
    endtask

    task automatic set_decode(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [31:0] rsd, input logic [31:0] rtd,
                              input logic [3:0] alu, input logic rw, input logic mr);
        bus.id_valid = 1'b1;   bus.id_rs_addr = rs;  bus.id_rt_addr = rt;
        bus.id_rd_addr = rd;   bus.id_rs_data = rsd; bus.id_rt_data = rtd;
        bus.id_alu_ctrl = alu; bus.id_reg_write = rw; bus.id_mem_read = mr;
        bus.id_use_imm = 1'b0; bus.id_imm = '0;       bus.id_shmt = '0;
        bus.id_mem_write = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busa"},  bus.BusA, 32'h0);
        check({tag, "_busb"},  bus.BusB, 32'h0);
        check({tag, "_shift"}, bus.shift, 32'h0);
        check({tag, "_alu"},   {28'h0, bus.ALUCtrl}, 32'h0);
        check({tag, "_ctrl"},  {26'h0, bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read,
                                bus.ex_mem_write, bus.load_use_stall, 1'b0}, 32'h0);
        check({tag, "_rd"},    {27'h0, bus.ex_rd}, 32'h0);
        check({tag, "_st"},    bus.ex_store_data, 32'h0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        clear_inputs();
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic capture
        set_decode(5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 4'b0010, 1'b1, 1'b0);
        #1;
        check("stall_idle", {31'h0, bus.load_use_stall}, 32'h0);
        step();
        check("cap_busa",  bus.BusA, 32'd5);
        check("cap_busb",  bus.BusB, 32'd7);
        check("cap_alu",   {28'h0, bus.ALUCtrl}, 32'h2);
        check("cap_valid", {31'h0, bus.ex_valid}, 32'h1);
        check("cap_rd",    {27'h0, bus.ex_rd}, 32'd5);
        check("cap_rw",    {31'h0, bus.ex_reg_write}, 32'h1);

        // Forwarding priority on rs=3
        set_decode(5'd3, 5'd6, 5'd9, 32'h11, 32'h22, 4'b0000, 1'b1, 1'b0);
        step();
        bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'hAAAA;
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd3; bus.memwb_result = 32'hBBBB;
        #1;
        check("fwd_exmem", bus.BusA, 32'hAAAA);
        check("fwd_rt_none", bus.BusB, 32'h22);
        bus.exmem_reg_write = 1'b0;
        #1;
        check("fwd_memwb", bus.BusA, 32'hBBBB);
        bus.memwb_reg_write = 1'b0;
        #1;
        check("fwd_none", bus.BusA, 32'h11);
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd6;
        #1;
        check("fwd_rt_memwb", bus.BusB, 32'hBBBB);
        check("fwd_rt_store", bus.ex_store_data, 32'hBBBB);
        clear_inputs();

        // r0 never forwarded
        set_decode(5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b0);
        step();
        bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'h1234;
        #1;
        check("r0_busa", bus.BusA, 32'h0);
        clear_inputs();

        // Load-use: load to r4 in EX, consumer reads r4 as rs
        set_decode(5'd1, 5'd2, 5'd4, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b1);
        step();
        check("ld_memread", {31'h0, bus.ex_mem_read}, 32'h1);
        set_decode(5'd4, 5'd9, 5'd7, 32'h40, 32'h90, 4'b0001, 1'b1, 1'b0);
        #1;
        check("lu_stall", {31'h0, bus.load_use_stall}, 32'h1);
        step();
        check("lu_bub_valid", {31'h0, bus.ex_valid}, 32'h0);
        check("lu_bub_rw",    {31'h0, bus.ex_reg_write}, 32'h0);
        check("lu_bub_rd",    {27'h0, bus.ex_rd}, 32'h0);
        check("lu_stall_drop", {31'h0, bus.load_use_stall}, 32'h0);
        step();
        check("lu_cap_valid", {31'h0, bus.ex_valid}, 32'h1);
        check("lu_cap_rd",    {27'h0, bus.ex_rd}, 32'd7);
        check("lu_cap_busa",  bus.BusA, 32'h40);

        // Load-use on rt is masked by use_imm
        set_decode(5'd1, 5'd2, 5'd4, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b1);
        step();
        set_decode(5'd1, 5'd4, 5'd8, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b0);
        bus.id_use_imm = 1'b1;
        #1;
        check("lu_rt_imm", {31'h0, bus.load_use_stall}, 32'h0);
        bus.id_use_imm = 1'b0;
        #1;
        check("lu_rt_reg", {31'h0, bus.load_use_stall}, 32'h1);
        bus.id_valid = 1'b0;
        #1;
        check("lu_idinv", {31'h0, bus.load_use_stall}, 32'h0);
        step();

        // Immediate select and store data
        set_decode(5'd1, 5'd8, 5'd2, 32'h0, 32'h33, 4'b0000, 1'b0, 1'b0);
        bus.id_use_imm = 1'b1; bus.id_imm = 32'h10;
        step();
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd8; bus.memwb_result = 32'h55;
        #1;
        check("imm_busb",  bus.BusB, 32'h10);
        check("imm_store", bus.ex_store_data, 32'h55);
        clear_inputs();

        // Logical shift right
        set_decode(5'd1, 5'd8, 5'd2, 32'h0, 32'h0, 4'b0011, 1'b1, 1'b0);
        bus.id_use_imm = 1'b1; bus.id_imm = 32'h80000000; bus.id_shmt = 5'd4;
        step();
        check("sh_busb",  bus.BusB, 32'h80000000);
        check("sh_shift", bus.shift, 32'h08000000);
        check("sh_shmt",  {27'h0, bus.shmt}, 32'd4);

        // Hold overrides flush; flush then bubbles once hold drops
        set_decode(5'd2, 5'd0, 5'd3, 32'h77, 32'h0, 4'b0101, 1'b1, 1'b0);
        step();
        bus.hold = 1'b1; bus.flush = 1'b1;
        set_decode(5'd9, 5'd9, 5'd9, 32'hDEAD, 32'hBEEF, 4'b1111, 1'b1, 1'b0);
        step();
        step();
        check("hold_busa",  bus.BusA, 32'h77);
        check("hold_valid", {31'h0, bus.ex_valid}, 32'h1);
        check("hold_rd",    {27'h0, bus.ex_rd}, 32'd3);
        check("hold_alu",   {28'h0, bus.ALUCtrl}, 32'h5);
        bus.hold = 1'b0;
        step();
        check("flush_valid", {31'h0, bus.ex_valid}, 32'h0);
        check("flush_rw",    {31'h0, bus.ex_reg_write}, 32'h0);
        check("flush_rd",    {27'h0, bus.ex_rd}, 32'h0);
        bus.flush = 1'b0;
        step();
        check("post_valid", {31'h0, bus.ex_valid}, 32'h1);
        check("post_busa",  bus.BusA, 32'hDEAD);

        // Asynchronous reset between clock edges
        clear_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
